// File: rtl/cv32e40x_pkg.sv
// Shared core types used by the register-file scoreboard.
package cv32e40x_pkg;

   typedef logic [4:0] rf_addr_t;

   localparam int REGFILE_NUM_READ_PORTS = 2;

   typedef enum logic {
      SB_RUN   = 1'b0,
      SB_DRAIN = 1'b1
   } sb_state_e;

endpackage

// File: rtl/cv32e40x_rf_scoreboard.sv
// Register-file scoreboard: tracks long-latency writes in flight between
// ID issue and WB retire, stalls ID on RAW/WAW/capacity conflicts and
// drains uncancellable bus transactions after a flush.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   SB_RUN   | normal tracking; long-latency issues set pending bits
//   SB_DRAIN | post-flush; bitmap empty, wait for outstanding retires
module cv32e40x_rf_scoreboard
   import cv32e40x_pkg::*;
#(
   parameter int NUM_READ_PORTS  = REGFILE_NUM_READ_PORTS,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                is_decoding_i,
   input  logic [NUM_READ_PORTS-1:0]           rf_re_i,
   input  rf_addr_t [NUM_READ_PORTS-1:0]       rf_raddr_i,
   input  logic                                rf_we_id_i,
   input  rf_addr_t                            rf_waddr_id_i,
   input  logic                                issue_i,
   input  logic                                issue_long_i,
   input  logic                                retire_i,
   input  rf_addr_t                            retire_waddr_i,
   input  logic                                flush_i,
   output logic                                stall_o,
   output logic [NUM_READ_PORTS-1:0]           fw_wb_hit_o,
   output logic                                busy_o,
   output logic                                draining_o,
   output logic                                err_o
);

   localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTSTANDING);

   logic [31:0]               pending_q, pending_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   sb_state_e                 state_q, state_d;
   logic                      err_q, err_d;

   logic                      run;
   logic                      set_ev, clr_ev, set_ok;
   logic                      cnt_full, cnt_zero;
   logic [NUM_READ_PORTS-1:0] hit, fw_hit, raw;
   logic                      waw, cap;

   assign run      = (state_q == SB_RUN);
   assign clr_ev   = retire_i;
   assign cnt_full = (cnt_q == CNT_MAX);
   assign cnt_zero = (cnt_q == '0);
   assign set_ev   = issue_i & issue_long_i & rf_we_id_i & (rf_waddr_id_i != '0)
                     & run & ~flush_i;
   // A set at full capacity only lands if a retire frees a slot the same cycle.
   assign set_ok   = set_ev & ~(cnt_full & ~clr_ev);

   // Outstanding counter: simultaneous set and clear cancel; clamp at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (set_ok && !clr_ev) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!set_ok && clr_ev && !cnt_zero) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Pending bitmap: flush wipes it; otherwise clear then set so a new producer wins.
   always_comb begin
      pending_d = pending_q;
      if (flush_i) begin
         pending_d = '0;
      end else if (run) begin
         if (clr_ev) pending_d[retire_waddr_i] = 1'b0;
         if (set_ok) pending_d[rf_waddr_id_i]  = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Sticky protocol error: overflow, underflow, or retire of an untracked register.
   always_comb begin
      err_d = err_q
              | (set_ev & cnt_full & ~clr_ev)
              | (clr_ev & cnt_zero)
              | (clr_ev & run & ~pending_q[retire_waddr_i]);
   end

   // Per-port RAW detection, with WB forwarding covering a same-cycle retire.
   always_comb begin
      hit    = '0;
      fw_hit = '0;
      raw    = '0;
      for (int i = 0; i < NUM_READ_PORTS; i++) begin
         hit[i]    = rf_re_i[i] & (rf_raddr_i[i] != '0) & pending_q[rf_raddr_i[i]];
         fw_hit[i] = hit[i] & clr_ev & (retire_waddr_i == rf_raddr_i[i]);
         raw[i]    = hit[i] & ~fw_hit[i];
      end
   end

   assign waw = rf_we_id_i & (rf_waddr_id_i != '0) & pending_q[rf_waddr_id_i]
                & ~(clr_ev & (retire_waddr_i == rf_waddr_id_i));
   assign cap = issue_long_i & rf_we_id_i & cnt_full & ~clr_ev;

   // Datapath registers: bitmap, counter and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SB_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: drain after a flush while writes remain in flight.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SB_RUN: begin
            if (flush_i) state_d = (cnt_d != '0) ? SB_DRAIN : SB_RUN;
         end
         SB_DRAIN: begin
            if (cnt_zero) state_d = SB_RUN;
         end
         default: state_d = SB_RUN;
      endcase
   end

   // FSM outputs: same-cycle stall and status.
   always_comb begin
      stall_o     = is_decoding_i & ((|raw) | waw | cap | (state_q == SB_DRAIN));
      fw_wb_hit_o = fw_hit;
      busy_o      = ~cnt_zero;
      draining_o  = (state_q == SB_DRAIN);
      err_o       = err_q;
   end

endmodule

// File: tb/tb_cv32e40x_rf_scoreboard.sv
// Directed bench for the register-file scoreboard (MAX_OUTSTANDING = 2).
module tb_cv32e40x_rf_scoreboard;
   import cv32e40x_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             is_decoding;
   logic [1:0]       rf_re;
   rf_addr_t [1:0]   rf_raddr;
   logic             rf_we_id;
   rf_addr_t         rf_waddr_id;
   logic             issue, issue_long, retire, flush;
   rf_addr_t         retire_waddr;
   logic             stall, busy, draining, err;
   logic [1:0]       fw_wb_hit;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [5:0] val;   // {stall, fw_wb_hit[1:0], busy, draining, err}
   } exp_t;

   exp_t exp_q[$];

   cv32e40x_rf_scoreboard #(
      .NUM_READ_PORTS  (2),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .is_decoding_i   (is_decoding),
      .rf_re_i         (rf_re),
      .rf_raddr_i      (rf_raddr),
      .rf_we_id_i      (rf_we_id),
      .rf_waddr_id_i   (rf_waddr_id),
      .issue_i         (issue),
      .issue_long_i    (issue_long),
      .retire_i        (retire),
      .retire_waddr_i  (retire_waddr),
      .flush_i         (flush),
      .stall_o         (stall),
      .fw_wb_hit_o     (fw_wb_hit),
      .busy_o          (busy),
      .draining_o      (draining),
      .err_o           (err)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [5:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic settle_check();
      exp_t       e;
      logic [5:0] obs;
      #3;
      obs = {stall, fw_wb_hit, busy, draining, err};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%b expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val)
         else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic drive(input logic dec, input logic iss, input logic lng, input logic we,
                        input logic [4:0] wa, input logic [1:0] re,
                        input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic ret, input logic [4:0] rwa, input logic fl);
      is_decoding  = dec;
      issue        = iss;
      issue_long   = lng;
      rf_we_id     = we;
      rf_waddr_id  = wa;
      rf_re        = re;
      rf_raddr[0]  = ra0;
      rf_raddr[1]  = ra1;
      retire       = ret;
      retire_waddr = rwa;
      flush        = fl;
   endtask

   // One cycle: drive at posedge+1, check at posedge+4, advance.
   task automatic step(input string tag, input logic dec, input logic iss, input logic lng,
                       input logic we, input logic [4:0] wa, input logic [1:0] re,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic ret, input logic [4:0] rwa, input logic fl,
                       input logic [5:0] val);
      drive(dec, iss, lng, we, wa, re, ra0, ra1, ret, rwa, fl);
      push_exp(tag, val);
      settle_check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1, 0, 0, 0, 0, 2'b11, 5, 3, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      push_exp("reset", 6'b0_00_0_0_0);
      settle_check();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      //    tag              dec iss lng we wa  re     ra0 ra1 ret rwa fl  {stall,fw,busy,drain,err}
      step("load_issue",     1,  1,  1,  1, 5,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_0_0_0);
      step("load_use",       1,  0,  0,  0, 0,  2'b01, 5,  0,  0,  0,  0, 6'b1_00_1_0_0);
      step("wb_fwd",         1,  0,  0,  0, 0,  2'b01, 5,  0,  1,  5,  0, 6'b0_01_1_0_0);
      step("fwd_done",       1,  0,  0,  0, 0,  2'b01, 5,  0,  0,  0,  0, 6'b0_00_0_0_0);

      step("cap_x1",         1,  1,  1,  1, 1,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_0_0_0);
      step("cap_x2",         1,  1,  1,  1, 2,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_1_0_0);
      step("cap_stall",      1,  0,  1,  1, 3,  2'b00, 0,  0,  0,  0,  0, 6'b1_00_1_0_0);
      step("cap_retire",     1,  1,  1,  1, 3,  2'b00, 0,  0,  1,  1,  0, 6'b0_00_1_0_0);
      step("cap_cnt_kept",   1,  0,  1,  1, 4,  2'b00, 0,  0,  0,  0,  0, 6'b1_00_1_0_0);
      step("x3_pending",     1,  0,  0,  0, 0,  2'b10, 0,  3,  0,  0,  0, 6'b1_00_1_0_0);
      step("x1_cleared",     1,  0,  0,  0, 0,  2'b01, 1,  0,  0,  0,  0, 6'b0_00_1_0_0);
      step("fwd_port1",      1,  0,  0,  0, 0,  2'b10, 0,  2,  1,  2,  0, 6'b0_10_1_0_0);
      step("ret_x3",         1,  0,  0,  0, 0,  2'b00, 0,  0,  1,  3,  0, 6'b0_00_1_0_0);

      step("waw_set",        1,  1,  1,  1, 7,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_0_0_0);
      step("waw",            1,  0,  0,  1, 7,  2'b00, 0,  0,  0,  0,  0, 6'b1_00_1_0_0);
      step("x0_issue",       1,  1,  1,  1, 0,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_1_0_0);
      step("x0_read",        1,  0,  1,  1, 8,  2'b11, 0,  0,  0,  0,  0, 6'b0_00_1_0_0);

      step("set_x9",         1,  1,  1,  1, 9,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_1_0_0);
      step("same_reg",       1,  1,  1,  1, 9,  2'b00, 0,  0,  1,  9,  0, 6'b0_00_1_0_0);
      step("same_reg_pend",  1,  0,  0,  0, 0,  2'b01, 9,  0,  0,  0,  0, 6'b1_00_1_0_0);
      step("same_reg_cnt",   1,  0,  1,  1, 10, 2'b00, 0,  0,  0,  0,  0, 6'b1_00_1_0_0);

      step("flush",          1,  0,  0,  0, 0,  2'b00, 0,  0,  0,  0,  1, 6'b0_00_1_0_0);
      step("drain_stall",    1,  0,  0,  0, 0,  2'b01, 7,  0,  0,  0,  0, 6'b1_00_1_1_0);
      step("drain_nodec",    0,  1,  1,  1, 11, 2'b00, 0,  0,  0,  0,  0, 6'b0_00_1_1_0);
      step("drain_ret1",     1,  0,  0,  0, 0,  2'b00, 0,  0,  1,  7,  0, 6'b1_00_1_1_0);
      step("drain_ret2",     1,  0,  0,  0, 0,  2'b00, 0,  0,  1,  9,  0, 6'b1_00_1_1_0);
      step("drain_zero",     1,  0,  0,  0, 0,  2'b00, 0,  0,  0,  0,  0, 6'b1_00_0_1_0);
      step("run_again",      1,  0,  0,  0, 0,  2'b01, 11, 0,  0,  0,  0, 6'b0_00_0_0_0);
      step("flush_idle",     1,  0,  0,  0, 0,  2'b00, 0,  0,  0,  0,  1, 6'b0_00_0_0_0);
      step("flush_idle_run", 1,  0,  0,  0, 0,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_0_0_0);

      step("underflow",      1,  0,  0,  0, 0,  2'b00, 0,  0,  1,  4,  0, 6'b0_00_0_0_0);
      step("err_sticky",     1,  0,  0,  0, 0,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_0_0_1);
      step("pre_x12",        1,  1,  1,  1, 12, 2'b00, 0,  0,  0,  0,  0, 6'b0_00_0_0_1);
      step("pre_x13",        1,  1,  1,  1, 13, 2'b00, 0,  0,  0,  0,  0, 6'b0_00_1_0_1);
      step("pre_flush",      1,  0,  0,  0, 0,  2'b00, 0,  0,  0,  0,  1, 6'b0_00_1_0_1);
      step("pre_reset",      1,  0,  0,  0, 0,  2'b01, 12, 0,  0,  0,  0, 6'b1_00_1_1_1);

      // Reset mid-DRAIN, between clock edges, with a read of a formerly pending register.
      drive(1, 0, 0, 0, 0, 2'b01, 12, 0, 0, 0, 0);
      rst_n = 1'b0;
      push_exp("reset_async", 6'b0_00_0_0_0);
      settle_check();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("post_reset",     1,  0,  0,  0, 0,  2'b01, 12, 0,  0,  0,  0, 6'b0_00_0_0_0);

      step("ovf_x1",         1,  1,  1,  1, 1,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_0_0_0);
      step("ovf_x2",         1,  1,  1,  1, 2,  2'b00, 0,  0,  0,  0,  0, 6'b0_00_1_0_0);
      step("ovf_x3",         1,  1,  1,  1, 3,  2'b00, 0,  0,  0,  0,  0, 6'b1_00_1_0_0);
      step("ovf_dropped",    1,  0,  0,  0, 0,  2'b10, 0,  3,  0,  0,  0, 6'b0_00_1_0_1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cv32e40x_rf_scoreboard.md
Name: cv32e40x_rf_scoreboard

Overview:
- Tracks register-file writes still in flight from long-latency producers (loads, multi-cycle ops) between ID issue and WB retire.
- Raises a hazard stall for ID on RAW, WAW or capacity conflicts, and reports when WB forwarding covers a hazard instead.
- Sequences pipeline flushes: outstanding bus transactions cannot be cancelled, so the block drains them before resuming issue.
- Sits beside the bypass/hazard controller; its stall is ORed into the ID stall by the controller.

Parameters:
- NUM_READ_PORTS, 2, number of ID register read ports checked.
- MAX_OUTSTANDING, 2, maximum long-latency writes in flight (1..7).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- is_decoding_i  input  1  controller FSM is in decode state
- rf_re_i  input  NUM_READ_PORTS  ID read enables
- rf_raddr_i  input  NUM_READ_PORTS x 5  ID read addresses
- rf_we_id_i  input  1  ID instruction writes RF
- rf_waddr_id_i  input  5  ID write address
- issue_i  input  1  ID instruction leaves ID this cycle (fire pulse)
- issue_long_i  input  1  issuing instruction is a long-latency producer
- retire_i  input  1  WB retires a long-latency write this cycle
- retire_waddr_i  input  5  WB write address
- flush_i  input  1  pipeline flush request (single-cycle pulse)
- stall_o  output  1  hold ID
- fw_wb_hit_o  output  NUM_READ_PORTS  read port hazard covered by WB forwarding this cycle
- busy_o  output  1  outstanding count non-zero
- draining_o  output  1  FSM in DRAIN
- err_o  output  1  sticky protocol error

Behaviour:
- State: pending[31:1] bitmap (pending[0] constant 0); cnt, width clog2(MAX_OUTSTANDING+1); FSM {RUN, DRAIN}; err flag.
- Reset values: bitmap 0, cnt 0, state RUN, err 0.
- Output reset values: stall_o 0, fw_wb_hit_o 0, busy_o 0, draining_o 0, err_o 0.
- Issue event: set_ev = issue_i & issue_long_i & rf_we_id_i & (rf_waddr_id_i != 0) & state==RUN & !flush_i.
- Retire event: clr_ev = retire_i.
- RUN, set_ev: pending[rf_waddr_id_i] <= 1 and cnt increments.
- RUN, clr_ev: pending[retire_waddr_i] <= 0 and cnt decrements.
- Same cycle set_ev and clr_ev: cnt unchanged. If the addresses are equal, set wins (a new producer supersedes).
- Per read port i:
  - hit_i = rf_re_i[i] & (rf_raddr_i[i] != 0) & pending[rf_raddr_i[i]].
  - fw_wb_hit_o[i] = hit_i & clr_ev & (retire_waddr_i == rf_raddr_i[i]).
  - raw_i = hit_i & !fw_wb_hit_o[i].
- WAW hazard: rf_we_id_i & (rf_waddr_id_i != 0) & pending[rf_waddr_id_i] & !(clr_ev & retire_waddr_i == rf_waddr_id_i).
- Capacity hazard: issue_long_i & rf_we_id_i & (cnt == MAX_OUTSTANDING) & !clr_ev.
- stall_o = is_decoding_i & (any raw_i | WAW | capacity | state==DRAIN). Combinational, same-cycle; no registered latency.
- flush_i in RUN:
  - Bitmap cleared next cycle; any set_ev that cycle is ignored.
  - cnt keeps (cnt minus a same-cycle retire).
  - Next state is DRAIN if that resulting cnt is non-zero, else RUN.
- DRAIN:
  - Retires decrement cnt and do not touch the bitmap.
  - Issues never set bits.
  - Leave for RUN in the cycle after cnt reaches 0.
  - flush_i in DRAIN: no effect beyond clearing the bitmap.
- Errors (sticky, cleared only by reset):
  - Overflow: set_ev with cnt==MAX_OUTSTANDING and no clr_ev sets err; the set is dropped and cnt saturates.
  - Underflow: clr_ev with cnt==0 sets err; cnt stays 0.
  - In RUN, clr_ev on a non-pending address also sets err; cnt still decrements.
- busy_o = (cnt != 0); draining_o = (state==DRAIN).
- Reset asserted mid-operation: all state returns to reset values asynchronously.

Decomposition:
- In cv32e40x_pkg:
  - scoreboard state enum sb_state_e {SB_RUN, SB_DRAIN}.
  - Reuse rf_addr_t and REGFILE_NUM_READ_PORTS (NUM_READ_PORTS default ties to it).
- No sub-module; bitmap, counter and FSM stay in one file.

Test Plan:
- Load-use: issue load x5 (long), next cycle ID reads x5 -> stall_o=1, busy_o=1, cnt=1. Retire x5 -> fw_wb_hit_o[0]=1, stall_o=0 that cycle; pending[5]=0 afterwards.
- Capacity: issue long x1, then x2 (MAX=2), then ID presents long write to x3 -> stall_o=1. Retire x1 in the same cycle -> stall_o=0; issue of x3 accepted and cnt stays 2.
- WAW and x0:
  - ID writes x7 while pending[7] set -> stall_o=1.
  - Long issue to x0 -> no bit set, cnt unchanged, no stall on a subsequent read of x0.
- Simultaneous set/clear of same reg: pending[9]=1, retire x9 and issue long x9 in one cycle -> pending[9]=1, cnt unchanged.
- Flush/drain:
  - cnt=2, flush_i -> bitmap=0, draining_o=1, stall_o=1 while decoding.
  - Two retires -> cnt=0 and RUN on the following cycle, stall_o=0.
  - A flush with cnt=0 -> stays RUN.
- Errors and reset:
  - Retire with cnt=0 -> err_o=1, cnt=0.
  - Assert rst_n=0 mid-DRAIN -> all outputs 0 immediately; err_o cleared.
